delay_timer: RTL and testbench

//   Programmable one-shot delay timer; the timing stage driven by fsm_moore.
//   It accepts a single-cycle START pulse, counts N prescaled ticks, then raises RDY.
//   RDY stays high until the next START, so the FSM can wait on it as a level.

---
 rtl/delay_timer.sv | 66 ++++++
 tb/tb_delay_timer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/delay_timer.sv
// delay_timer: one-shot delay of N prescaled ticks, RDY held high until the next START.
module delay_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] N,
    output logic             RDY,
    output logic             BUSY,
    output logic             TICK,
    output logic [WIDTH-1:0] TICKS_LEFT
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [PW-1:0]    pre, pre_n;
    logic             tick_n;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            pre   <= '0;
            TICK  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pre   <= pre_n;
            TICK  <= tick_n;
        end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pre_n   = pre;
        tick_n  = 1'b0;
        if (ABORT) begin
            state_n = IDLE;
            cnt_n   = '0;
            pre_n   = '0;
        end else if (START) begin
            state_n = (N != '0) ? RUN : DONE;
            cnt_n   = N;
            pre_n   = PRE_TOP;
        end else if (state == RUN) begin
            pre_n = (pre != '0) ? pre - 1'b1 : PRE_TOP;
            if (pre == '0) begin
                tick_n  = 1'b1;
                // cnt is at least 1 in RUN; the last tick lands on DONE instead of wrapping
                state_n = (cnt <= WIDTH'(1)) ? DONE : RUN;
                cnt_n   = (cnt <= WIDTH'(1)) ? '0 : cnt - 1'b1;
            end
        end
    end

    assign RDY        = (state == DONE);
    assign BUSY       = (state == RUN);
    assign TICKS_LEFT = cnt;
endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: directed checks of delay_timer with PRESCALE=4, WIDTH=8.
module tb_delay_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] n = '0;
    logic       rdy, busy, tick;
    logic [7:0] ticks_left;
    int         n_chk = 0;
    int         n_err = 0;

    delay_timer #(.WIDTH(8), .PRESCALE(4)) dut (
        .clk(clk), .reset(reset), .START(start), .ABORT(abort), .N(n),
        .RDY(rdy), .BUSY(busy), .TICK(tick), .TICKS_LEFT(ticks_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int r, input int b, input int t, input int tl);
        check({tag, ".rdy"}, int'(rdy), r);
        check({tag, ".busy"}, int'(busy), b);
        check({tag, ".tick"}, int'(tick), t);
        check({tag, ".left"}, int'(ticks_left), tl);
    endtask

    task automatic pulse_start(input logic [7:0] v);
        start = 1'b1;
        n = v;
        step();
        start = 1'b0;
        n = 8'hAA;
    endtask

    initial begin
        #22;
        outs("reset", 0, 0, 0, 0);
        reset = 1'b1;

        // 1: N=3 -> ticks at k+4, k+8, k+12; RDY at k+12
        pulse_start(8'd3);
        outs("t1.k", 0, 1, 0, 3);
        for (int i = 1; i <= 12; i++) begin
            step();
            outs($sformatf("t1.k+%0d", i), int'(i == 12), int'(i < 12), int'(i % 4 == 0), 3 - i / 4);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            check("t1.hold.rdy", int'(rdy), 1);
            check("t1.hold.tick", int'(tick), 0);
        end

        // 2: from DONE, N=1
        pulse_start(8'd1);
        outs("t2.j", 0, 1, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            outs($sformatf("t2.j+%0d", i), int'(i == 4), int'(i < 4), int'(i == 4), int'(i < 4));
        end

        // 3: N=0 -> DONE right away, BUSY never rises
        pulse_start(8'd0);
        outs("t3.k", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            outs("t3.hold", 1, 0, 0, 0);
        end

        // 4: N=5 retriggered with N=2 at the seventh edge
        pulse_start(8'd5);
        for (int i = 1; i <= 6; i++) step();
        outs("t4.pre", 0, 1, 0, 4);
        pulse_start(8'd2);
        outs("t4.m", 0, 1, 0, 2);
        for (int i = 1; i <= 8; i++) begin
            step();
            outs($sformatf("t4.m+%0d", i), int'(i == 8), int'(i < 8), int'(i % 4 == 0), 2 - i / 4);
        end

        // 5: ABORT beats a simultaneous START
        pulse_start(8'd4);
        for (int i = 1; i <= 5; i++) step();
        abort = 1'b1;
        pulse_start(8'd4);
        abort = 1'b0;
        outs("t5.abort", 0, 0, 0, 0);
        step();
        step();
        outs("t5.idle", 0, 0, 0, 0);
        pulse_start(8'd1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("t5.k+%0d.rdy", i), int'(rdy), int'(i == 4));
        end

        // 6: async reset mid-RUN, then a fresh N=3 run
        pulse_start(8'd3);
        for (int i = 1; i <= 4; i++) step();
        check("t6.pre.busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        outs("t6.reset", 0, 0, 0, 0);
        step();
        outs("t6.held", 0, 0, 0, 0);
        #3 reset = 1'b1;
        step();
        outs("t6.idle", 0, 0, 0, 0);
        pulse_start(8'd3);
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("t6.k+%0d.rdy", i), int'(rdy), int'(i == 12));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
